dht11_emulator: RTL and testbench

Single-wire DHT11 sensor model (responder side) for the cold-storage FPGA: answers a host start pulse on the shared open-drain `dht_data` line with the DHT11 ack sequence and a 40-bit humidity/temperature frame. Used for bench/HIL testing of the host-side DHT11 reader and as a stand-in sensor on boards without a fitted DHT11. Sits at the pad, in place of the physical sensor.

---
 rtl/dht11_pkg.sv | 45 ++++
 rtl/dht11_sync.sv | 39 +++
 rtl/dht11_emulator.sv | 214 +++++++++++++++++++++
 tb/tb_dht11_emulator.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared DHT11 protocol constants and emulator state encoding.
// The host-side reader imports the same constants.
package dht11_pkg;

    localparam int unsigned ACK_LOW_US   = 80;
    localparam int unsigned ACK_HIGH_US  = 80;
    localparam int unsigned BIT_LOW_US   = 50;
    localparam int unsigned BIT0_HIGH_US = 26;
    localparam int unsigned BIT1_HIGH_US = 70;
    localparam int unsigned END_LOW_US   = 50;

    localparam int unsigned FRAME_BITS = 40;

    // A low seen this many cycles into a released phase is the host, not our own echo.
    localparam logic [31:0] CONTEND_CYCLES = 32'd4;

    typedef enum logic [3:0] {
        StIdle,
        StHostLow,
        StWaitRel,
        StRespDly,
        StAckLow,
        StAckHigh,
        StBitLow,
        StBitHigh,
        StEndLow,
        StCooldown
    } dht_state_e;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [7:0] hum_int,
        input logic [7:0] hum_dec,
        input logic [7:0] temp_int,
        input logic [7:0] temp_dec,
        input logic       bad_csum
    );
        logic [7:0] csum;
        csum = hum_int + hum_dec + temp_int + temp_dec;
        if (bad_csum) begin
            csum = ~csum;
        end
        return {hum_int, hum_dec, temp_int, temp_dec, csum};
    endfunction

endpackage

// File: rtl/dht11_sync.sv
// Two-flop synchronizer for the DHT11 data line, with rise/fall strobes
// derived from the synchronized level.
module dht11_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle line is pulled high, so reset to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/dht11_emulator.sv
// DHT11 responder: detects a host start pulse on the open-drain line, then sends
// the ack sequence and a snapshotted 40-bit humidity/temperature frame.
module dht11_emulator
    import dht11_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US = 100,
    parameter int unsigned START_MIN_US  = 1000,
    parameter int unsigned RESP_DLY_US   = 30,
    parameter int unsigned COOLDOWN_US   = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    input  logic       bad_csum,
    inout  wire        dht_data,
    output logic       busy,
    output logic       frame_done,
    output logic       abort
);

    localparam logic [31:0] START_LAST    = 32'(START_MIN_US * CYCLES_PER_US - 1);
    localparam logic [31:0] RESP_LAST     = 32'(RESP_DLY_US * CYCLES_PER_US - 1);
    localparam logic [31:0] ACK_LOW_LAST  = 32'(ACK_LOW_US * CYCLES_PER_US - 1);
    localparam logic [31:0] ACK_HIGH_LAST = 32'(ACK_HIGH_US * CYCLES_PER_US - 1);
    localparam logic [31:0] BIT_LOW_LAST  = 32'(BIT_LOW_US * CYCLES_PER_US - 1);
    localparam logic [31:0] BIT0_LAST     = 32'(BIT0_HIGH_US * CYCLES_PER_US - 1);
    localparam logic [31:0] BIT1_LAST     = 32'(BIT1_HIGH_US * CYCLES_PER_US - 1);
    localparam logic [31:0] END_LOW_LAST  = 32'(END_LOW_US * CYCLES_PER_US - 1);
    localparam logic [31:0] COOL_LAST     = 32'(COOLDOWN_US * CYCLES_PER_US - 1);
    localparam logic [5:0]  LAST_BIT      = 6'(FRAME_BITS - 1);

    dht_state_e            state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [5:0]            bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  abort_q, abort_d;

    logic        sync_level, sync_rise, sync_fall;
    logic [31:0] cnt_inc;
    logic [31:0] high_last;
    logic        contend;

    dht11_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_i   (dht_data),
        .level_o (sync_level),
        .rise_o  (sync_rise),
        .fall_o  (sync_fall)
    );

    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    assign high_last = shreg_q[FRAME_BITS-1] ? BIT1_LAST : BIT0_LAST;
    assign contend   = !sync_level && (cnt_q >= CONTEND_CYCLES);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        frame_done_d = 1'b0;
        abort_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The entry cycle is the first counted low cycle.
                if (sync_fall || !sync_level) begin
                    state_d = StHostLow;
                    cnt_d   = 32'd1;
                end
            end
            StHostLow: begin
                if (sync_level) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q >= START_LAST) begin
                        state_d = StWaitRel;
                    end
                end
            end
            StWaitRel: begin
                if (sync_rise) begin
                    // Detection cycle already counts toward the response delay.
                    state_d   = StRespDly;
                    cnt_d     = 32'd1;
                    bit_idx_d = '0;
                    shreg_d   = build_frame(hum_int, hum_dec, temp_int, temp_dec, bad_csum);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRespDly: begin
                if (cnt_q >= RESP_LAST) begin
                    state_d = StAckLow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StAckLow: begin
                if (cnt_q == ACK_LOW_LAST) begin
                    state_d = StAckHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StAckHigh: begin
                if (contend) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (cnt_q == ACK_HIGH_LAST) begin
                    state_d = StBitLow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StBitLow: begin
                if (cnt_q == BIT_LOW_LAST) begin
                    state_d = StBitHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StBitHigh: begin
                if (contend) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (cnt_q == high_last) begin
                    cnt_d     = '0;
                    shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    bit_idx_d = bit_idx_q + 6'd1;
                    state_d   = (bit_idx_q == LAST_BIT) ? StEndLow : StBitLow;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StEndLow: begin
                if (cnt_q == END_LOW_LAST) begin
                    state_d      = StCooldown;
                    cnt_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StCooldown: begin
                if (cnt_q == COOL_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (!en) begin
            state_d      = StIdle;
            cnt_d        = '0;
            bit_idx_d    = '0;
            frame_done_d = 1'b0;
            abort_d      = 1'b0;
        end

        oe_d   = state_d inside {StAckLow, StBitLow, StEndLow};
        busy_d = !(state_d inside {StIdle, StHostLow, StWaitRel});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            oe_q         <= oe_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            abort_q      <= abort_d;
        end
    end

    // Gating with en makes a disable release the line in the same cycle.
    assign dht_data   = (oe_q && en) ? 1'b0 : 1'bz;
    assign busy       = busy_q & en;
    assign frame_done = frame_done_q & en;
    assign abort      = abort_q & en;

endmodule

// File: tb/tb_dht11_emulator.sv
// Bench for dht11_emulator: a timeline model of the expected line/outputs per cycle,
// plus a line decoder that recovers the transmitted frame bits.
module tb_dht11_emulator;

    localparam int unsigned CPU      = 2;
    localparam int unsigned START_US = 200;
    localparam int unsigned RESP_US  = 30;
    localparam int unsigned COOL_US  = 100;
    localparam int          T        = START_US * CPU;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
    logic       bad_csum;
    logic       host_low;
    wire        dht_data;
    logic       busy, frame_done, abort;

    pullup (dht_data);
    assign dht_data = host_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht11_emulator #(
        .CYCLES_PER_US (CPU),
        .START_MIN_US  (START_US),
        .RESP_DLY_US   (RESP_US),
        .COOLDOWN_US   (COOL_US)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .hum_int    (hum_int),
        .hum_dec    (hum_dec),
        .temp_int   (temp_int),
        .temp_dec   (temp_dec),
        .bad_csum   (bad_csum),
        .dht_data   (dht_data),
        .busy       (busy),
        .frame_done (frame_done),
        .abort      (abort)
    );

    typedef struct packed {
        logic dut_low;
        logic busy;
        logic fd;
        logic abort;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    logic [39:0] last_word;
    int          last_bits;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d,
                                                input logic bad);
        int s;
        int cs;
        s  = int'(a) + int'(b) + int'(c) + int'(d);
        cs = s % 256;
        if (bad) cs = 255 - cs;
        return {a, b, c, d, 8'(cs)};
    endfunction

    // Sample index (counted from the release edge) where bit i's low phase starts.
    function automatic int bit_start(input logic [39:0] f, input int i);
        int idx;
        idx = RESP_US * CPU + 2 + (80 + 80) * CPU;
        for (int j = 0; j < i; j++) idx += (50 + (f[39 - j] ? 70 : 26)) * CPU;
        return idx;
    endfunction

    task automatic push_seg(input int n, input logic lo, input logic bz, input logic fd,
                            input logic ab);
        exp_t e;
        e.dut_low = lo;
        e.busy    = bz;
        e.fd      = fd;
        e.abort   = ab;
        for (int i = 0; i < n; i++) expq.push_back(e);
    endtask

    task automatic expect_frame(input logic [39:0] f);
        push_seg(3, 1'b0, 1'b0, 1'b0, 1'b0);
        push_seg(RESP_US * CPU - 1, 1'b0, 1'b1, 1'b0, 1'b0);
        push_seg(80 * CPU, 1'b1, 1'b1, 1'b0, 1'b0);
        push_seg(80 * CPU, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 39; i >= 0; i--) begin
            push_seg(50 * CPU, 1'b1, 1'b1, 1'b0, 1'b0);
            push_seg((f[i] ? 70 : 26) * CPU, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        push_seg(50 * CPU, 1'b1, 1'b1, 1'b0, 1'b0);
        push_seg(1, 1'b0, 1'b1, 1'b1, 1'b0);
        push_seg(COOL_US * CPU - 1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Host holds the line low for l cycles; returns just after the release edge.
    task automatic host_pulse(input int l, input bit accept, input logic [39:0] f);
        @(posedge clk);
        #1 host_low = 1'b1;
        repeat (l) @(posedge clk);
        #1 host_low = 1'b0;
        last_word = '0;
        last_bits = 0;
        if (accept) expect_frame(f);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (expq.size() > 0 && i < 20000) begin
            @(posedge clk);
            i++;
        end
        chk("drain", 64'(expq.size()), 64'd0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the timeline model.
    initial begin
        exp_t e;
        logic exp_line;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) e = expq.pop_front();
            else e = '0;
            exp_line = !(e.dut_low || host_low);
            chk("line", 64'(dht_data), 64'(exp_line));
            chk("busy", 64'(busy), 64'(e.busy));
            chk("frame_done", 64'(frame_done), 64'(e.fd));
            chk("abort", 64'(abort), 64'(e.abort));
        end
    end

    // Decode bits from the length of each high run while busy.
    initial begin
        int          hi_run;
        logic [39:0] word;
        int          nbits;
        hi_run = 0;
        word   = '0;
        nbits  = 0;
        forever begin
            @(negedge clk);
            if (!busy) begin
                hi_run = 0;
                nbits  = 0;
            end else if (dht_data === 1'b1) begin
                hi_run++;
            end else begin
                if (hi_run == 26 * CPU) begin
                    word = {word[38:0], 1'b0};
                    nbits++;
                end else if (hi_run == 70 * CPU) begin
                    word = {word[38:0], 1'b1};
                    nbits++;
                end
                hi_run = 0;
            end
            if (frame_done === 1'b1) begin
                last_word = word;
                last_bits = nbits;
            end
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] f;
        int          k;
        int          l;

        rst_n    = 1'b1;
        en       = 1'b1;
        host_low = 1'b0;
        hum_int  = 8'h37;
        hum_dec  = 8'h00;
        temp_int = 8'h19;
        temp_dec = 8'h00;
        bad_csum = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_line", 64'(dht_data), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fd", 64'(frame_done), 64'd0);
        chk("rst_abort", 64'(abort), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("pin_csum", model_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0), 64'h3700190050);
        chk("pin_bad", model_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b1), 64'h37001900AF);
        repeat (20) @(posedge clk);

        // Glitch: well below the start threshold.
        host_pulse(100 * CPU, 1'b0, '0);
        repeat (300) @(posedge clk);
        #1 chk("glitch_busy", 64'(busy), 64'd0);

        // Nominal frame.
        f = model_frame(hum_int, hum_dec, temp_int, temp_dec, bad_csum);
        host_pulse(250 * CPU, 1'b1, f);
        chk("nom_len", 64'(expq.size()), 64'd7642);
        wait_drain();
        chk("nom_frame", last_word, 64'h3700190050);
        chk("nom_bits", 64'(last_bits), 64'd40);

        // Bad checksum.
        bad_csum = 1'b1;
        f = model_frame(hum_int, hum_dec, temp_int, temp_dec, bad_csum);
        host_pulse(250 * CPU, 1'b1, f);
        wait_drain();
        chk("bad_frame", last_word, 64'h37001900AF);
        bad_csum = 1'b0;

        // Snapshot: payload change during bit 3 is ignored.
        f = model_frame(hum_int, hum_dec, temp_int, temp_dec, bad_csum);
        host_pulse(250 * CPU, 1'b1, f);
        repeat (bit_start(f, 3) + 10) @(posedge clk);
        #1 hum_int = 8'hFF;
        wait_drain();
        chk("snap_frame", last_word, 64'h3700190050);
        hum_int = 8'h37;

        // Contention: host pulls low inside ACK_HIGH.
        f = model_frame(hum_int, hum_dec, temp_int, temp_dec, bad_csum);
        host_pulse(250 * CPU, 1'b1, f);
        k = RESP_US * CPU + 2 + 80 * CPU + 10;
        repeat (k) @(posedge clk);
        #1 host_low = 1'b1;
        while (expq.size() > 3) void'(expq.pop_back());
        push_seg(1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1 host_low = 1'b0;
        wait_drain();
        repeat (50) @(posedge clk);
        host_pulse(250 * CPU, 1'b1, f);
        wait_drain();
        chk("post_abort_frame", last_word, 64'h3700190050);

        // Reset at bit 20.
        host_pulse(250 * CPU, 1'b1, f);
        repeat (bit_start(f, 20) + 3) @(posedge clk);
        #1 chk("pre_rst_line", 64'(dht_data), 64'd0);
        #1;
        expq.delete();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_line", 64'(dht_data), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_fd", 64'(frame_done), 64'd0);
        chk("mid_rst_abort", 64'(abort), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(posedge clk);

        // Enable low at bit 20.
        host_pulse(250 * CPU, 1'b1, f);
        repeat (bit_start(f, 20) + 3) @(posedge clk);
        #1 chk("pre_en_line", 64'(dht_data), 64'd0);
        #1;
        expq.delete();
        en = 1'b0;
        #1;
        chk("en_line", 64'(dht_data), 64'd1);
        chk("en_busy", 64'(busy), 64'd0);
        chk("en_fd", 64'(frame_done), 64'd0);
        chk("en_abort", 64'(abort), 64'd0);
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
        repeat (400) @(posedge clk);
        chk("en_no_frame", 64'(last_bits), 64'd0);

        // Threshold boundary: T-1 rejected, T accepted.
        host_pulse(T - 1, 1'b0, '0);
        repeat (300) @(posedge clk);
        hum_int  = 8'($urandom);
        hum_dec  = 8'($urandom);
        temp_int = 8'($urandom);
        temp_dec = 8'($urandom);
        f = model_frame(hum_int, hum_dec, temp_int, temp_dec, bad_csum);
        host_pulse(T, 1'b1, f);
        wait_drain();
        chk("edge_frame", last_word, 64'(f));

        // Random payloads and start lengths.
        for (int n = 0; n < 2; n++) begin
            hum_int  = 8'($urandom);
            hum_dec  = 8'($urandom);
            temp_int = 8'($urandom);
            temp_dec = 8'($urandom);
            bad_csum = 1'($urandom_range(0, 1));
            l = T + int'($urandom_range(1, 60));
            f = model_frame(hum_int, hum_dec, temp_int, temp_dec, bad_csum);
            host_pulse(l, 1'b1, f);
            wait_drain();
            chk("rand_frame", last_word, 64'(f));
            chk("rand_bits", 64'(last_bits), 64'd40);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
